// File: rtl/traffic_light_ctrl_if.sv
// traffic_light_ctrl_if: request/mode inputs and light/countdown outputs of the traffic light controller
interface traffic_light_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             ped_req;
    logic             flash_en;
    logic [2:0]       main_lights;
    logic [2:0]       side_lights;
    logic [CNT_W-1:0] remain;
    logic             tick_1s;

    modport master (
        output ped_req, flash_en,
        input  main_lights, side_lights, remain, tick_1s
    );

    modport slave (
        input  ped_req, flash_en,
        output main_lights, side_lights, remain, tick_1s
    );
endinterface

// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: main/side road light sequencer with 1 s prescaler, pedestrian shortening and yellow flash mode
module traffic_light_ctrl #(
    parameter int TICK_CYCLES = 50_000_000,
    parameter int MG_S        = 30,
    parameter int MY_S        = 3,
    parameter int SG_S        = 20,
    parameter int SY_S        = 3,
    parameter int AR_S        = 1,
    parameter int PED_MIN_S   = 5,
    parameter int CNT_W       = 8
) (
    input logic                 clk,
    input logic                 rst,
    traffic_light_ctrl_if.slave bus
);
    function automatic bit bad_dur(input int d);
        return d < 1 || (d >>> CNT_W) != 0;
    endfunction

    if (TICK_CYCLES < 2 || bad_dur(MG_S) || bad_dur(MY_S) || bad_dur(SG_S) || bad_dur(SY_S) ||
        bad_dur(AR_S) || bad_dur(PED_MIN_S)) begin : g_bad_params
        $error("traffic_light_ctrl: illegal parameter set");
    end

    localparam int PW = $clog2(TICK_CYCLES);
    localparam logic [PW-1:0]    P_LAST = PW'(TICK_CYCLES - 1);
    localparam logic [CNT_W-1:0] D_MG   = CNT_W'(MG_S);
    localparam logic [CNT_W-1:0] D_MY   = CNT_W'(MY_S);
    localparam logic [CNT_W-1:0] D_SG   = CNT_W'(SG_S);
    localparam logic [CNT_W-1:0] D_SY   = CNT_W'(SY_S);
    localparam logic [CNT_W-1:0] D_AR   = CNT_W'(AR_S);
    localparam logic [CNT_W-1:0] D_PED  = CNT_W'(PED_MIN_S);
    localparam logic [CNT_W-1:0] D_MGP  = MG_S < PED_MIN_S ? D_MG : D_PED;
    localparam logic [2:0] RED = 3'b100, YEL = 3'b010, GRN = 3'b001, OFF = 3'b000;

    typedef enum logic [2:0] {MG, MY, AR1, SG, SY, AR2, FLASH} state_t;

    state_t           state, state_nxt, succ;
    logic [PW-1:0]    presc, presc_nxt;
    logic [CNT_W-1:0] remain, remain_nxt, succ_dur;
    logic             pending, pending_nxt, phase, phase_nxt, pend_eff, tick;
    logic [2:0]       main_nxt, side_nxt;

    assign tick       = presc == P_LAST;
    assign pend_eff   = pending | bus.ped_req;
    assign bus.remain = remain;

    // state, prescaler, countdown, pedestrian flag and flash phase registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= AR2;
            presc   <= '0;
            remain  <= D_AR;
            pending <= 1'b0;
            phase   <= 1'b1;
        end else begin
            state   <= state_nxt;
            presc   <= presc_nxt;
            remain  <= remain_nxt;
            pending <= pending_nxt;
            phase   <= phase_nxt;
        end
    end

    // next state: flash entry/exit beats phase expiry, expiry beats pedestrian shortening
    always_comb begin
        succ = state == MG  ? MY  :
               state == MY  ? AR1 :
               state == AR1 ? SG  :
               state == SG  ? SY  :
               state == SY  ? AR2 : MG;
        succ_dur = succ == MG  ? (pend_eff ? D_MGP : D_MG) :
                   succ == MY  ? D_MY :
                   succ == SG  ? D_SG :
                   succ == SY  ? D_SY : D_AR;
        state_nxt  = state;
        remain_nxt = remain;
        presc_nxt  = tick ? '0 : presc + 1'b1;
        phase_nxt  = phase;
        if (state == FLASH && !bus.flash_en) begin
            state_nxt  = AR2;
            remain_nxt = D_AR;
            presc_nxt  = '0;
            phase_nxt  = 1'b1;
        end else if (state == FLASH) begin
            phase_nxt = tick ? ~phase : phase;
        end else if (bus.flash_en) begin
            state_nxt  = FLASH;
            remain_nxt = '0;
            presc_nxt  = '0;
            phase_nxt  = 1'b1;
        end else if (tick && remain == CNT_W'(1)) begin
            state_nxt  = succ;
            remain_nxt = succ_dur;
        end else if (state == MG && pend_eff && remain > D_PED) begin
            remain_nxt = D_PED;
        end else if (tick) begin
            remain_nxt = remain - 1'b1;
        end
        pending_nxt = (state_nxt == SG && state != SG) ? 1'b0 : pend_eff;
    end

    // light pattern that the upcoming state will show
    always_comb begin
        main_nxt = state_nxt == MG    ? GRN :
                   state_nxt == MY    ? YEL :
                   state_nxt == FLASH ? (phase_nxt ? YEL : OFF) : RED;
        side_nxt = state_nxt == SG    ? GRN :
                   state_nxt == SY    ? YEL :
                   state_nxt == FLASH ? (phase_nxt ? YEL : OFF) : RED;
    end

    // registered light and tick outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.main_lights <= RED;
            bus.side_lights <= RED;
            bus.tick_1s     <= 1'b0;
        end else begin
            bus.main_lights <= main_nxt;
            bus.side_lights <= side_nxt;
            bus.tick_1s     <= tick;
        end
    end
endmodule

// File: tb/tb_traffic_light_ctrl.sv
// tb_traffic_light_ctrl: directed scenarios for the traffic light controller with a 4-cycle tick
module tb_traffic_light_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    logic [13:0] obs;

    traffic_light_ctrl_if #(.CNT_W(8)) bus ();

    traffic_light_ctrl #(
        .TICK_CYCLES(4), .MG_S(6), .MY_S(2), .SG_S(4), .SY_S(2),
        .AR_S(1), .PED_MIN_S(2), .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    assign obs = {bus.main_lights, bus.side_lights, bus.remain};

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        bus.ped_req  = 1'b0;
        bus.flash_en = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        bus.ped_req  = 1'b0;
        bus.flash_en = 1'b0;
        rst = 1'b1;
        step(6);
        checks++;
        if (obs !== {3'b100, 3'b100, 8'd1}) begin
            errors++;
            $display("FAIL reset_state got %b want %b", obs, {3'b100, 3'b100, 8'd1});
        end
        checks++;
        if (bus.tick_1s !== 1'b0) begin
            errors++;
            $display("FAIL reset_tick got %b want 0", bus.tick_1s);
        end
    endtask

    task automatic test_normal_cycle;
        int cp_n [10] = '{3, 4, 8, 27, 28, 36, 40, 56, 64, 68};
        logic [13:0] cp_v [10] = '{
            {3'b100, 3'b100, 8'd1}, {3'b001, 3'b100, 8'd6}, {3'b001, 3'b100, 8'd5},
            {3'b001, 3'b100, 8'd1}, {3'b010, 3'b100, 8'd2}, {3'b100, 3'b100, 8'd1},
            {3'b100, 3'b001, 8'd4}, {3'b100, 3'b010, 8'd2}, {3'b100, 3'b100, 8'd1},
            {3'b001, 3'b100, 8'd6}};
        int k = 0;
        do_reset();
        for (int n = 1; n <= 68; n++) begin
            step(1);
            checks++;
            if (bus.tick_1s !== (n % 4 == 0)) begin
                errors++;
                $display("FAIL normal_tick cycle %0d got %b want %b", n, bus.tick_1s, n % 4 == 0);
            end
            if (k < 10 && n == cp_n[k]) begin
                checks++;
                if (obs !== cp_v[k]) begin
                    errors++;
                    $display("FAIL normal_seq cycle %0d got %b want %b", n, obs, cp_v[k]);
                end
                k++;
            end
        end
    endtask

    task automatic test_ped_shorten;
        do_reset();
        step(8);
        bus.ped_req = 1'b1;
        step(1);
        bus.ped_req = 1'b0;
        checks++;
        if (obs !== {3'b001, 3'b100, 8'd2}) begin
            errors++;
            $display("FAIL ped_shorten got %b want %b", obs, {3'b001, 3'b100, 8'd2});
        end
        step(6);
        checks++;
        if (obs !== {3'b001, 3'b100, 8'd1}) begin
            errors++;
            $display("FAIL ped_mg_last got %b want %b", obs, {3'b001, 3'b100, 8'd1});
        end
        step(1);
        checks++;
        if (obs !== {3'b010, 3'b100, 8'd2}) begin
            errors++;
            $display("FAIL ped_my_entry got %b want %b", obs, {3'b010, 3'b100, 8'd2});
        end
        step(40);
        checks++;
        if (obs !== {3'b001, 3'b100, 8'd6}) begin
            errors++;
            $display("FAIL ped_cleared_next_mg got %b want %b", obs, {3'b001, 3'b100, 8'd6});
        end
    endtask

    task automatic test_ped_in_sg;
        do_reset();
        step(40);
        bus.ped_req = 1'b1;
        step(1);
        bus.ped_req = 1'b0;
        step(27);
        checks++;
        if (obs !== {3'b001, 3'b100, 8'd2}) begin
            errors++;
            $display("FAIL sg_ped_mg_load got %b want %b", obs, {3'b001, 3'b100, 8'd2});
        end
        step(8);
        checks++;
        if (obs !== {3'b010, 3'b100, 8'd2}) begin
            errors++;
            $display("FAIL sg_ped_my_entry got %b want %b", obs, {3'b010, 3'b100, 8'd2});
        end
    endtask

    task automatic test_ped_at_tick;
        do_reset();
        step(27);
        bus.ped_req = 1'b1;
        step(1);
        bus.ped_req = 1'b0;
        checks++;
        if (obs !== {3'b010, 3'b100, 8'd2}) begin
            errors++;
            $display("FAIL tick_wins got %b want %b", obs, {3'b010, 3'b100, 8'd2});
        end
    endtask

    task automatic test_ped_drop;
        do_reset();
        step(39);
        bus.ped_req = 1'b1;
        step(1);
        bus.ped_req = 1'b0;
        checks++;
        if (obs !== {3'b100, 3'b001, 8'd4}) begin
            errors++;
            $display("FAIL drop_sg_entry got %b want %b", obs, {3'b100, 3'b001, 8'd4});
        end
        step(28);
        checks++;
        if (obs !== {3'b001, 3'b100, 8'd6}) begin
            errors++;
            $display("FAIL drop_next_mg got %b want %b", obs, {3'b001, 3'b100, 8'd6});
        end
    endtask

    task automatic test_flash;
        do_reset();
        step(44);
        bus.flash_en = 1'b1;
        step(1);
        checks++;
        if (obs !== {3'b010, 3'b010, 8'd0}) begin
            errors++;
            $display("FAIL flash_entry got %b want %b", obs, {3'b010, 3'b010, 8'd0});
        end
        step(3);
        checks++;
        if (obs !== {3'b010, 3'b010, 8'd0}) begin
            errors++;
            $display("FAIL flash_lit_hold got %b want %b", obs, {3'b010, 3'b010, 8'd0});
        end
        step(1);
        checks++;
        if (obs !== {3'b000, 3'b000, 8'd0}) begin
            errors++;
            $display("FAIL flash_dark got %b want %b", obs, {3'b000, 3'b000, 8'd0});
        end
        step(4);
        checks++;
        if (obs !== {3'b010, 3'b010, 8'd0}) begin
            errors++;
            $display("FAIL flash_relit got %b want %b", obs, {3'b010, 3'b010, 8'd0});
        end
        bus.flash_en = 1'b0;
        step(1);
        checks++;
        if (obs !== {3'b100, 3'b100, 8'd1}) begin
            errors++;
            $display("FAIL flash_exit got %b want %b", obs, {3'b100, 3'b100, 8'd1});
        end
        step(3);
        checks++;
        if (obs !== {3'b100, 3'b100, 8'd1}) begin
            errors++;
            $display("FAIL flash_ar2_hold got %b want %b", obs, {3'b100, 3'b100, 8'd1});
        end
        step(1);
        checks++;
        if (obs !== {3'b001, 3'b100, 8'd6}) begin
            errors++;
            $display("FAIL flash_resume_mg got %b want %b", obs, {3'b001, 3'b100, 8'd6});
        end
    endtask

    task automatic test_flash_ped;
        do_reset();
        bus.flash_en = 1'b1;
        step(1);
        checks++;
        if (obs !== {3'b010, 3'b010, 8'd0}) begin
            errors++;
            $display("FAIL flash_from_ar2 got %b want %b", obs, {3'b010, 3'b010, 8'd0});
        end
        bus.ped_req = 1'b1;
        step(1);
        bus.ped_req  = 1'b0;
        bus.flash_en = 1'b0;
        step(5);
        checks++;
        if (obs !== {3'b001, 3'b100, 8'd2}) begin
            errors++;
            $display("FAIL flash_ped_mg got %b want %b", obs, {3'b001, 3'b100, 8'd2});
        end
    endtask

    task automatic test_reset_mid;
        do_reset();
        step(42);
        bus.ped_req = 1'b1;
        step(1);
        bus.ped_req = 1'b0;
        step(15);
        checks++;
        if (obs !== {3'b100, 3'b010, 8'd2}) begin
            errors++;
            $display("FAIL mid_sy got %b want %b", obs, {3'b100, 3'b010, 8'd2});
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({obs, bus.tick_1s} !== {3'b100, 3'b100, 8'd1, 1'b0}) begin
            errors++;
            $display("FAIL async_reset got %b want %b", {obs, bus.tick_1s}, {3'b100, 3'b100, 8'd1, 1'b0});
        end
        rst = 1'b0;
        step(3);
        checks++;
        if ({obs, bus.tick_1s} !== {3'b100, 3'b100, 8'd1, 1'b0}) begin
            errors++;
            $display("FAIL post_reset_ar2 got %b want %b", {obs, bus.tick_1s}, {3'b100, 3'b100, 8'd1, 1'b0});
        end
        step(1);
        checks++;
        if ({obs, bus.tick_1s} !== {3'b001, 3'b100, 8'd6, 1'b1}) begin
            errors++;
            $display("FAIL post_reset_mg got %b want %b", {obs, bus.tick_1s}, {3'b001, 3'b100, 8'd6, 1'b1});
        end
    endtask

    initial begin
        test_reset();
        test_normal_cycle();
        test_ped_shorten();
        test_ped_in_sg();
        test_ped_at_tick();
        test_ped_drop();
        test_flash();
        test_flash_ped();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/traffic_light_ctrl.md
TRAFFIC_LIGHT_CTRL -- requirements
Module: traffic_light_ctrl

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
  TICK_CYCLES  50_000_000  clk cycles per 1 s tick
  MG_S  30  main-green seconds
  MY_S  3  main-yellow seconds
  SG_S  20  side-green seconds
  SY_S  3  side-yellow seconds
  AR_S  1  all-red seconds
  PED_MIN_S  5  max remaining main-green seconds once pedestrian request pending
  CNT_W  8  width of remain output
REQ-002 The block SHALL have these ports, one per line: name  direction  width  meaning.
  clk  in  1  single clock, all logic rising-edge
  rst  in  1  asynchronous reset, active-high
  ped_req  in  1  pedestrian request, one-cycle pulse, already debounced
  flash_en  in  1  level; 1 = yellow-flash maintenance mode
  main_lights  out  3  {red,yellow,green} main road
  side_lights  out  3  {red,yellow,green} side road
  remain  out  CNT_W  seconds left in current phase, binary, for the seg driver
  tick_1s  out  1  one-cycle pulse per second
REQ-003 Every duration parameter and PED_MIN_S SHALL be >=1 and <2^CNT_W; TICK_CYCLES SHALL be >=2; the implementation SHALL fail elaboration otherwise.
REQ-004 All outputs SHALL be registered.

Function
REQ-005 Prescaler SHALL count 0..TICK_CYCLES-1 and wrap; tick_1s SHALL be 1 in the cycle after the prescaler reaches TICK_CYCLES-1.
REQ-006 States SHALL be MG, MY, AR1, SG, SY, AR2, FLASH; normal sequence MG->MY->AR1->SG->SY->AR2->MG.
REQ-007 Lights per state: MG main=001 side=100; MY main=010 side=100; AR1/AR2 both 100; SG main=100 side=001; SY main=100 side=010; FLASH both 010 or both 000 per flash phase.
REQ-008 On entering a normal state, remain SHALL load that state's duration; each tick SHALL decrement remain by 1; a tick with remain==1 SHALL move to the next state and load its duration in the same cycle, so each phase lasts exactly duration ticks.
REQ-009 remain SHALL never underflow; remain==0 occurs only in FLASH.
REQ-010 ped_req SHALL set a ped_pending flag; ped_pending SHALL clear on entry to SG; further requests while pending SHALL be ignored.
REQ-011 In MG with ped_pending=1 and remain>PED_MIN_S, remain SHALL be set to PED_MIN_S on the next cycle, prescaler untouched; if remain<=PED_MIN_S it SHALL be unchanged.
REQ-012 Entering MG with ped_pending=1 SHALL load min(MG_S, PED_MIN_S).
REQ-013 Same cycle tick with remain==1 and ped shortening in MG: transition SHALL win.
REQ-014 ped_req arriving the same cycle ped_pending clears (SG entry) SHALL be dropped.
REQ-015 flash_en=1 SHALL force FLASH from any state on the next cycle, from any remain value; prescaler SHALL restart at 0, remain=0, flash phase=lit.
REQ-016 In FLASH the flash phase SHALL toggle on every tick (1 s on, 1 s off); ped_req SHALL still set ped_pending.
REQ-017 flash_en falling SHALL move FLASH->AR2 on the next cycle with remain=AR_S and prescaler restarted at 0; normal sequence then resumes at MG.
REQ-018 flash_en change taking effect in the same cycle as a normal transition SHALL take priority over it.

Reset
REQ-019 While rst=1 (asynchronous assert): state=AR2, prescaler=0, ped_pending=0, flash phase=lit, main_lights=100, side_lights=100, remain=AR_S, tick_1s=0.
REQ-020 On rst release the first tick SHALL occur TICK_CYCLES cycles later; reset mid-phase SHALL discard all state, including a pending request.

Verification (TICK_CYCLES=4, MG_S=6, MY_S=2, SG_S=4, SY_S=2, AR_S=1, PED_MIN_S=2, CNT_W=8)
REQ-021 Reset release, no inputs -> AR2 4 clk, MG 24 clk, MY 8, AR1 4, SG 16, SY 8, AR2 4; remain counts 6..1 in MG; tick_1s every 4th clk.
REQ-022 ped_req in MG at remain=5 -> remain=2 next cycle, MG ends 2 ticks later; ped_pending clears on SG entry.
REQ-023 ped_req during SG -> pending held, next MG loads remain=2.
REQ-024 ped_req in MG at remain=1 on tick cycle -> MY entered, remain=2, no shortening.
REQ-025 flash_en=1 during SG remain=3 -> next cycle both 010, remain=0; lights alternate 010/000 every 4 clk; flash_en=0 -> AR2, remain=1, then MG remain=6.
REQ-026 rst pulse mid-SY with ped_pending=1 -> immediate both-red, remain=1, ped_pending=0, next MG remain=6.
